// File: rtl/wb_stage_if.sv
// Bundle of the MEM-side, data-memory response and register-file write
// signals of the writeback stage. The slave view belongs to wb_stage.
interface wb_stage_if;
    // MEM stage instruction presentation
    logic        M_valid;
    logic        M_wb_ena;
    logic [4:0]  M_wb_addr;
    logic [31:0] M_alu_result;
    logic        M_load;
    logic [2:0]  M_load_type;
    logic [1:0]  M_byte_off;
    // Data memory read response
    logic        D_rvalid;
    logic [31:0] D_rdata;
    // Writeback stage outputs
    logic        W_stall;
    logic        W_w_ena;
    logic [4:0]  W_w_addr;
    logic [31:0] W_w_data;
    logic        W_err;

    modport slave (
        input  M_valid,
        input  M_wb_ena,
        input  M_wb_addr,
        input  M_alu_result,
        input  M_load,
        input  M_load_type,
        input  M_byte_off,
        input  D_rvalid,
        input  D_rdata,
        output W_stall,
        output W_w_ena,
        output W_w_addr,
        output W_w_data,
        output W_err
    );

    modport master (
        output M_valid,
        output M_wb_ena,
        output M_wb_addr,
        output M_alu_result,
        output M_load,
        output M_load_type,
        output M_byte_off,
        output D_rvalid,
        output D_rdata,
        input  W_stall,
        input  W_w_ena,
        input  W_w_addr,
        input  W_w_data,
        input  W_err
    );
endinterface

// File: rtl/wb_stage.sv
// MEM/WB pipeline stage of the MIPS core. Retires ALU results one cycle after
// acceptance; for loads it parks in WAIT until the data memory responds, then
// lane-selects and extends the word before writing the register file.
// Stray responses, misaligned loads and response timeouts set a sticky error.
// TIMEOUT must be >= 1 and must fit in CNT_W bits (2**CNT_W > TIMEOUT).
module wb_stage #(
    parameter int TIMEOUT = 16,
    parameter int CNT_W   = 5
) (
    input  logic       clk,
    input  logic       rst,
    wb_stage_if.slave  bus
);

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_WAIT = 1'b1
    } state_t;

    localparam logic [2:0] LT_LB  = 3'b000;
    localparam logic [2:0] LT_LH  = 3'b001;
    localparam logic [2:0] LT_LBU = 3'b100;
    localparam logic [2:0] LT_LHU = 3'b101;

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

    // Select the addressed lane of the response word and extend it.
    // Unassigned load-type codes behave as a full-word load.
    function automatic logic [31:0] f_extract(
        input logic [31:0] rdata,
        input logic [2:0]  ltype,
        input logic [1:0]  off
    );
        logic [7:0]  v_byte;
        logic [15:0] v_half;
        logic [31:0] v_res;
        v_byte = rdata[8*off +: 8];
        v_half = rdata[16*off[1] +: 16];
        case (ltype)
            LT_LB:   v_res = {{24{v_byte[7]}}, v_byte};
            LT_LBU:  v_res = {24'h00_0000, v_byte};
            LT_LH:   v_res = {{16{v_half[15]}}, v_half};
            LT_LHU:  v_res = {16'h0000, v_half};
            default: v_res = rdata;
        endcase
        return v_res;
    endfunction

    // Halfwords need an even offset, words a zero offset; bytes never fault.
    function automatic logic f_misaligned(
        input logic [2:0] ltype,
        input logic [1:0] off
    );
        logic v_bad;
        case (ltype)
            LT_LB, LT_LBU: v_bad = 1'b0;
            LT_LH, LT_LHU: v_bad = off[0];
            default:       v_bad = (off != 2'b00);
        endcase
        return v_bad;
    endfunction

    // Registered state
    state_t            r_state;
    logic [CNT_W-1:0]  r_cnt;
    logic              r_ld_wb_ena;
    logic [4:0]        r_ld_addr;
    logic [2:0]        r_ld_type;
    logic [1:0]        r_ld_off;
    logic              r_w_ena;
    logic [4:0]        r_w_addr;
    logic [31:0]       r_w_data;
    logic              r_err;

    // Next-state values
    state_t            w_state_nxt;
    logic [CNT_W-1:0]  w_cnt_nxt;
    logic              w_ld_wb_ena_nxt;
    logic [4:0]        w_ld_addr_nxt;
    logic [2:0]        w_ld_type_nxt;
    logic [1:0]        w_ld_off_nxt;
    logic              w_w_ena_nxt;
    logic [4:0]        w_w_addr_nxt;
    logic [31:0]       w_w_data_nxt;
    logic              w_err_nxt;

    // Decoded helpers
    logic              w_stall;
    logic              w_accept;
    logic [31:0]       w_ld_data;
    logic              w_ld_misalign;
    logic              w_ld_writes;
    logic              w_alu_writes;

    // Stall depends on registered state only, so no combinational path
    // runs from M_* or D_* back to the upstream stage.
    assign w_stall       = (r_state == ST_WAIT);
    assign w_accept      = bus.M_valid && !w_stall;
    assign w_ld_data     = f_extract(bus.D_rdata, r_ld_type, r_ld_off);
    assign w_ld_misalign = f_misaligned(r_ld_type, r_ld_off);
    assign w_ld_writes   = r_ld_wb_ena && (r_ld_addr != 5'd0);
    assign w_alu_writes  = bus.M_wb_ena && (bus.M_wb_addr != 5'd0);

    // Next-state and writeback decode for the IDLE/WAIT controller.
    always_comb begin
        w_state_nxt     = r_state;
        w_cnt_nxt       = r_cnt;
        w_ld_wb_ena_nxt = r_ld_wb_ena;
        w_ld_addr_nxt   = r_ld_addr;
        w_ld_type_nxt   = r_ld_type;
        w_ld_off_nxt    = r_ld_off;
        w_w_ena_nxt     = 1'b0;
        w_w_addr_nxt    = r_w_addr;
        w_w_data_nxt    = r_w_data;
        w_err_nxt       = r_err;

        case (r_state)
            ST_IDLE: begin
                // A response with nothing outstanding is a protocol fault;
                // it is dropped but does not block a same-cycle accept.
                if (bus.D_rvalid) begin
                    w_err_nxt = 1'b1;
                end else begin
                    w_err_nxt = r_err;
                end

                if (w_accept) begin
                    if (bus.M_load) begin
                        w_state_nxt     = ST_WAIT;
                        w_cnt_nxt       = {CNT_W{1'b0}};
                        w_ld_wb_ena_nxt = bus.M_wb_ena;
                        w_ld_addr_nxt   = bus.M_wb_addr;
                        w_ld_type_nxt   = bus.M_load_type;
                        w_ld_off_nxt    = bus.M_byte_off;
                    end else if (w_alu_writes) begin
                        w_w_ena_nxt  = 1'b1;
                        w_w_addr_nxt = bus.M_wb_addr;
                        w_w_data_nxt = bus.M_alu_result;
                    end else begin
                        // Writes to $0 or non-writing instructions retire
                        // silently; address/data keep their last values.
                        w_w_ena_nxt = 1'b0;
                    end
                end else begin
                    w_state_nxt = ST_IDLE;
                end
            end

            ST_WAIT: begin
                if (bus.D_rvalid) begin
                    w_state_nxt = ST_IDLE;
                    w_cnt_nxt   = {CNT_W{1'b0}};
                    if (w_ld_misalign) begin
                        // Response consumed, result discarded.
                        w_err_nxt = 1'b1;
                    end else if (w_ld_writes) begin
                        w_w_ena_nxt  = 1'b1;
                        w_w_addr_nxt = r_ld_addr;
                        w_w_data_nxt = w_ld_data;
                    end else begin
                        w_w_ena_nxt = 1'b0;
                    end
                end else if (r_cnt == CNT_LAST) begin
                    // Memory never answered: abandon the load.
                    w_state_nxt = ST_IDLE;
                    w_cnt_nxt   = {CNT_W{1'b0}};
                    w_err_nxt   = 1'b1;
                end else begin
                    w_cnt_nxt = r_cnt + {{(CNT_W-1){1'b0}}, 1'b1};
                end
            end

            default: begin
                // Unreachable encoding: recover to IDLE and flag it.
                w_state_nxt = ST_IDLE;
                w_cnt_nxt   = {CNT_W{1'b0}};
                w_err_nxt   = 1'b1;
            end
        endcase
    end

    // State, latched load context and registered writeback outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= ST_IDLE;
            r_cnt       <= {CNT_W{1'b0}};
            r_ld_wb_ena <= 1'b0;
            r_ld_addr   <= 5'd0;
            r_ld_type   <= 3'b000;
            r_ld_off    <= 2'b00;
            r_w_ena     <= 1'b0;
            r_w_addr    <= 5'd0;
            r_w_data    <= 32'h0000_0000;
            r_err       <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_cnt       <= w_cnt_nxt;
            r_ld_wb_ena <= w_ld_wb_ena_nxt;
            r_ld_addr   <= w_ld_addr_nxt;
            r_ld_type   <= w_ld_type_nxt;
            r_ld_off    <= w_ld_off_nxt;
            r_w_ena     <= w_w_ena_nxt;
            r_w_addr    <= w_w_addr_nxt;
            r_w_data    <= w_w_data_nxt;
            r_err       <= w_err_nxt;
        end
    end

    assign bus.W_stall  = w_stall;
    assign bus.W_w_ena  = r_w_ena;
    assign bus.W_w_addr = r_w_addr;
    assign bus.W_w_data = r_w_data;
    assign bus.W_err    = r_err;

endmodule

// File: tb/tb_wb_stage.sv
// Directed testbench for wb_stage (TIMEOUT=4). Inputs change and outputs are
// sampled 1 ns after each rising edge.
module tb_wb_stage;

    logic clk;
    logic rst;
    int   checks;
    int   failures;

    wb_stage_if bus_if ();

    wb_stage #(
        .TIMEOUT (4),
        .CNT_W   (3)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus_if)
    );

    // 10 ns clock
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic idle_inputs();
        bus_if.M_valid      = 1'b0;
        bus_if.M_wb_ena     = 1'b0;
        bus_if.M_wb_addr    = 5'd0;
        bus_if.M_alu_result = 32'h0000_0000;
        bus_if.M_load       = 1'b0;
        bus_if.M_load_type  = 3'b000;
        bus_if.M_byte_off   = 2'b00;
        bus_if.D_rvalid     = 1'b0;
        bus_if.D_rdata      = 32'h0000_0000;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        idle_inputs();
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        checks++;
        if ({bus_if.W_stall, bus_if.W_w_ena, bus_if.W_w_addr, bus_if.W_w_data, bus_if.W_err} !== 40'd0) begin
            failures++;
            $display("FAIL reset_outputs: stall=%b ena=%b addr=%0d data=%h err=%b, expected all 0",
                     bus_if.W_stall, bus_if.W_w_ena, bus_if.W_w_addr, bus_if.W_w_data, bus_if.W_err);
        end
        // Issue a load, then reset while it is outstanding.
        bus_if.M_valid = 1'b1; bus_if.M_load = 1'b1; bus_if.M_wb_ena = 1'b1;
        bus_if.M_wb_addr = 5'd4; bus_if.M_load_type = 3'b010;
        tick();
        idle_inputs();
        checks++;
        if (bus_if.W_stall !== 1'b1) begin
            failures++;
            $display("FAIL reset_load_stall: got %b expected 1", bus_if.W_stall);
        end
        rst = 1'b1;
        tick();
        rst = 1'b0;
        checks++;
        if ({bus_if.W_stall, bus_if.W_w_ena, bus_if.W_w_addr, bus_if.W_w_data, bus_if.W_err} !== 40'd0) begin
            failures++;
            $display("FAIL reset_mid_wait: stall=%b ena=%b addr=%0d data=%h err=%b, expected all 0",
                     bus_if.W_stall, bus_if.W_w_ena, bus_if.W_w_addr, bus_if.W_w_data, bus_if.W_err);
        end
        // The late response now arrives in IDLE: stray.
        bus_if.D_rvalid = 1'b1; bus_if.D_rdata = 32'hDEAD_BEEF;
        tick();
        idle_inputs();
        checks++;
        if ({bus_if.W_w_ena, bus_if.W_stall, bus_if.W_err} !== 3'b001) begin
            failures++;
            $display("FAIL stray_rvalid: ena/stall/err got %b%b%b expected 001",
                     bus_if.W_w_ena, bus_if.W_stall, bus_if.W_err);
        end
    endtask

    task automatic test_back_to_back();
        logic [4:0]  addrs [3];
        logic [31:0] datas [3];
        logic        exp_ena [3];
        addrs = '{5'd5, 5'd0, 5'd7};
        datas = '{32'h0000_0011, 32'h0000_0022, 32'h0000_0033};
        exp_ena = '{1'b1, 1'b0, 1'b1};
        do_reset();
        bus_if.M_valid = 1'b1; bus_if.M_wb_ena = 1'b1; bus_if.M_load = 1'b0;
        bus_if.M_wb_addr = addrs[0]; bus_if.M_alu_result = datas[0];
        for (int i = 0; i < 3; i++) begin
            tick();
            if (i < 2) begin
                bus_if.M_wb_addr = addrs[i+1]; bus_if.M_alu_result = datas[i+1];
            end else begin
                idle_inputs();
            end
            checks++;
            if (bus_if.W_w_ena !== exp_ena[i]) begin
                failures++;
                $display("FAIL b2b_ena[%0d]: got %b expected %b", i, bus_if.W_w_ena, exp_ena[i]);
            end
            if (exp_ena[i]) begin
                checks++;
                if (bus_if.W_w_addr !== addrs[i] || bus_if.W_w_data !== datas[i]) begin
                    failures++;
                    $display("FAIL b2b_write[%0d]: got $%0d=%h expected $%0d=%h",
                             i, bus_if.W_w_addr, bus_if.W_w_data, addrs[i], datas[i]);
                end
            end
        end
        tick();
        checks++;
        if (bus_if.W_w_ena !== 1'b0 || bus_if.W_stall !== 1'b0 || bus_if.W_err !== 1'b0) begin
            failures++;
            $display("FAIL b2b_tail: ena=%b stall=%b err=%b expected 0 0 0",
                     bus_if.W_w_ena, bus_if.W_stall, bus_if.W_err);
        end
    endtask

    task automatic run_load(input string name, input logic [2:0] ltype, input logic [1:0] off,
                            input logic [31:0] rdata, input int waits, input logic exp_ena,
                            input logic [31:0] exp_data, input logic exp_err);
        int stall_cycles;
        int early_writes;
        stall_cycles = 0;
        early_writes = 0;
        do_reset();
        bus_if.M_valid = 1'b1; bus_if.M_load = 1'b1; bus_if.M_wb_ena = 1'b1;
        bus_if.M_wb_addr = 5'd9; bus_if.M_alu_result = 32'h5555_AAAA;
        bus_if.M_load_type = ltype; bus_if.M_byte_off = off;
        tick();
        idle_inputs();
        if (bus_if.W_stall === 1'b1) stall_cycles++;
        if (bus_if.W_w_ena !== 1'b0) early_writes++;
        for (int i = 0; i < waits; i++) begin
            tick();
            if (bus_if.W_stall === 1'b1) stall_cycles++;
            if (bus_if.W_w_ena !== 1'b0) early_writes++;
        end
        bus_if.D_rvalid = 1'b1; bus_if.D_rdata = rdata;
        tick();
        idle_inputs();
        checks++;
        if (bus_if.W_stall !== 1'b0 || stall_cycles != waits + 1 || early_writes != 0) begin
            failures++;
            $display("FAIL %s_stall: stall_now=%b cycles=%0d early_writes=%0d expected 0 %0d 0",
                     name, bus_if.W_stall, stall_cycles, waits + 1, early_writes);
        end
        checks++;
        if (bus_if.W_w_ena !== exp_ena || bus_if.W_err !== exp_err) begin
            failures++;
            $display("FAIL %s_flags: ena=%b err=%b expected %b %b",
                     name, bus_if.W_w_ena, bus_if.W_err, exp_ena, exp_err);
        end
        if (exp_ena) begin
            checks++;
            if (bus_if.W_w_data !== exp_data || bus_if.W_w_addr !== 5'd9) begin
                failures++;
                $display("FAIL %s_data: got $%0d=%h expected $9=%h",
                         name, bus_if.W_w_addr, bus_if.W_w_data, exp_data);
            end
        end
        tick();
        checks++;
        if (bus_if.W_w_ena !== 1'b0) begin
            failures++;
            $display("FAIL %s_pulse: ena got %b expected 0", name, bus_if.W_w_ena);
        end
    endtask

    task automatic test_loads();
        run_load("lb",  3'b000, 2'd3, 32'h80FF_0102, 2, 1'b1, 32'hFFFF_FF80, 1'b0);
        run_load("lbu", 3'b100, 2'd3, 32'h80FF_0102, 2, 1'b1, 32'h0000_0080, 1'b0);
        run_load("lh",  3'b001, 2'd2, 32'h9ABC_1234, 0, 1'b1, 32'hFFFF_9ABC, 1'b0);
        run_load("lhu", 3'b101, 2'd2, 32'h9ABC_1234, 1, 1'b1, 32'h0000_9ABC, 1'b0);
        run_load("lw",  3'b010, 2'd0, 32'h9ABC_1234, 0, 1'b1, 32'h9ABC_1234, 1'b0);
        run_load("lb0", 3'b000, 2'd0, 32'h80FF_0102, 0, 1'b1, 32'h0000_0002, 1'b0);
    endtask

    task automatic test_misaligned();
        run_load("lw_mis", 3'b010, 2'd1, 32'h1234_5678, 0, 1'b0, 32'h0000_0000, 1'b1);
    endtask

    task automatic test_timeout();
        int stall_cycles;
        int pulses;
        logic released;
        stall_cycles = 0;
        pulses = 0;
        released = 1'b0;
        do_reset();
        bus_if.M_valid = 1'b1; bus_if.M_load = 1'b1; bus_if.M_wb_ena = 1'b1;
        bus_if.M_wb_addr = 5'd12; bus_if.M_load_type = 3'b010;
        tick();
        idle_inputs();
        for (int i = 0; i < 10 && !released; i++) begin
            if (bus_if.W_w_ena !== 1'b0) pulses++;
            if (bus_if.W_stall === 1'b1) begin
                stall_cycles++;
                tick();
            end else begin
                released = 1'b1;
            end
        end
        checks++;
        if (!released || stall_cycles != 4 || pulses != 0) begin
            failures++;
            $display("FAIL timeout_stall: released=%b cycles=%0d pulses=%0d expected 1 4 0",
                     released, stall_cycles, pulses);
        end
        checks++;
        if (bus_if.W_err !== 1'b1) begin
            failures++;
            $display("FAIL timeout_err: got %b expected 1", bus_if.W_err);
        end
        // Following non-load is accepted normally.
        bus_if.M_valid = 1'b1; bus_if.M_wb_ena = 1'b1;
        bus_if.M_wb_addr = 5'd3; bus_if.M_alu_result = 32'hCAFE_0001;
        tick();
        idle_inputs();
        checks++;
        if (bus_if.W_w_ena !== 1'b1 || bus_if.W_w_addr !== 5'd3 || bus_if.W_w_data !== 32'hCAFE_0001) begin
            failures++;
            $display("FAIL timeout_next: got ena=%b $%0d=%h expected ena=1 $3=cafe0001",
                     bus_if.W_w_ena, bus_if.W_w_addr, bus_if.W_w_data);
        end
    endtask

    task automatic test_stray_with_accept();
        do_reset();
        bus_if.M_valid = 1'b1; bus_if.M_wb_ena = 1'b1;
        bus_if.M_wb_addr = 5'd21; bus_if.M_alu_result = 32'h0BAD_F00D;
        bus_if.D_rvalid = 1'b1; bus_if.D_rdata = 32'h1111_2222;
        tick();
        idle_inputs();
        checks++;
        if (bus_if.W_w_ena !== 1'b1 || bus_if.W_w_data !== 32'h0BAD_F00D || bus_if.W_err !== 1'b1) begin
            failures++;
            $display("FAIL stray_accept: ena=%b data=%h err=%b expected 1 0badf00d 1",
                     bus_if.W_w_ena, bus_if.W_w_data, bus_if.W_err);
        end
    endtask

    initial begin
        checks = 0;
        failures = 0;
        rst = 1'b1;
        idle_inputs();
        test_reset();
        test_back_to_back();
        test_loads();
        test_misaligned();
        test_timeout();
        test_stray_with_accept();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/wb_stage.md
Name: wb_stage

Overview:
- MEM/WB pipeline stage of the MIPS core; directly upstream of the register file write port and sole driver of W_w_ena/W_w_addr/W_w_data.
- Registers ALU results from MEM and returns them for writeback.
- For loads, waits on the data-memory response, then byte/halfword-selects and sign/zero-extends the data.
- Stalls upstream while a load is outstanding; flags protocol faults and timeouts.

Parameters:
- TIMEOUT, 16, max cycles in WAIT before the load is abandoned; must be >= 1.
- CNT_W, 5, width of the wait counter; must satisfy 2^CNT_W > TIMEOUT.

Ports:
- clk  in  1  clock, rising edge
- rst  in  1  synchronous reset, active-high
- M_valid  in  1  MEM stage presents an instruction this cycle
- M_wb_ena  in  1  instruction writes a GPR
- M_wb_addr  in  5  destination GPR
- M_alu_result  in  32  result for non-loads
- M_load  in  1  instruction is a load
- M_load_type  in  3  000 LB, 001 LH, 010 LW, 100 LBU, 101 LHU
- M_byte_off  in  2  address bits [1:0] of the load
- D_rvalid  in  1  data memory read response valid
- D_rdata  in  32  response word, little-endian lanes
- W_stall  out  1  upstream must hold M_* and not advance
- W_w_ena  out  1  register file write enable
- W_w_addr  out  5  register file write address
- W_w_data  out  32  register file write data
- W_err  out  1  sticky fault flag

Behaviour:
- Single clock (clk); reset (rst) is synchronous and active-high.
- Reset: state=IDLE, counter=0, W_w_ena=0, W_w_addr=0, W_w_data=0, W_err=0. Any outstanding load is dropped without a write. A D_rvalid in the reset cycle is ignored.
- Accept condition: M_valid && !W_stall. W_stall = (state==WAIT); it is a combinational decode of registered state only.
- W_w_ena/W_w_addr/W_w_data are registered. W_w_ena is a one-cycle pulse per retired instruction and is 0 otherwise. W_w_addr and W_w_data hold their last values when W_w_ena=0.
- IDLE, accept, non-load:
  - Next cycle: W_w_ena = M_wb_ena && (M_wb_addr != 0), W_w_addr = M_wb_addr, W_w_data = M_alu_result.
  - Back-to-back accepts give a write every cycle.
- IDLE, accept, load:
  - Latch wb_ena, addr, load_type, byte_off; next state WAIT; counter=0.
  - No write is produced.
  - The memory response arrives no earlier than the next cycle.
- WAIT, D_rvalid=1:
  - Next cycle: W_w_ena = latched wb_ena && (addr != 0), W_w_data = extended data; state returns to IDLE, so W_stall=0 that cycle.
  - Minimum load latency: accept at t, rvalid at t+1, write at t+2.
- WAIT, D_rvalid=0: counter increments. When counter reaches TIMEOUT-1 and rvalid is still 0, next cycle is IDLE, no write, W_err=1.
- D_rvalid=1 while in IDLE: response ignored, W_err=1, state unchanged. If the same cycle also accepts an instruction, that instruction is processed normally.
- Extraction: lane = D_rdata[8*off +: 8] for bytes, D_rdata[16*off[1] +: 16] for halves.
  - LB/LH sign-extend; LBU/LHU zero-extend; LW passes the full word.
  - Codes 011, 110, 111 are treated as LW.
- Misalignment: LH/LHU with off[0]=1, or LW with off != 0. The response is still awaited and consumed, the write is suppressed, and W_err=1.
- W_err clears only on rst.
- M_* values are don't-care when M_valid=0 or W_stall=1.

Test Plan:
- Reset mid-WAIT: issue a load, assert rst for 1 cycle, then rvalid -> no write, W_stall=0 after reset, W_err=1 (stray rvalid in IDLE), all outputs 0 during reset.
- Non-load stream: 3 consecutive accepts to $5=0x11, $0=0x22, $7=0x33 -> W_w_ena pattern 1,0,1 on cycles t+1..t+3; data 0x11 and 0x33; $0 never written.
- LB/LBU off=3, D_rdata=0x80FF_0102 after 2 wait cycles:
  - LB -> W_w_data=0xFFFF_FF80.
  - LBU -> 0x0000_0080.
  - W_stall high exactly 3 cycles for each.
- LH/LHU off=2, D_rdata=0x9ABC_1234:
  - LH -> 0xFFFF_9ABC.
  - LHU -> 0x0000_9ABC.
  - LW off=0 -> 0x9ABC_1234.
- Timeout with TIMEOUT=4: load accepted, no rvalid -> W_stall high 4 cycles, then IDLE, W_err=1, no W_w_ena pulse; a following non-load is accepted normally.
- Misaligned LW off=1: rvalid at t+1 -> no write at t+2, W_err=1, W_stall released at t+2.
